// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a small source-tagged response FIFO so a stalled consumer loses nothing.

module alu (
    input  logic [3:0]  funct,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out
);

    always_comb begin
        out = '0;
        case (funct)
            4'b0000: out = in1 + in2;
            4'b0001: out = in1 - in2;
            4'b0010: out = in1 & in2;
            4'b0011: out = in1 | in2;
            4'b0100: out = ~(in1 | in2);
            4'b0101: out = in1 ^ in2;
            // shifts move in2 by the low five bits of in1
            4'b0110: out = in2 << in1[4:0];
            4'b0111: out = $signed(in2) >>> in1[4:0];
            4'b1000: out = in2 >> in1[4:0];
            4'b1001: out = {31'b0, $signed(in1) < $signed(in2)};
            4'b1010: out = {31'b0, in1 < in2};
            4'b1111: out = in2;
            default: out = '0;
        endcase
    end

endmodule

module alu_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_funct,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_funct,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_out,
    output logic        resp_src
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic          src_mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          prio;
    logic [31:0]   last_out;
    logic          last_src;

    logic          can_accept;
    logic          gnt;
    logic          push;
    logic          pop;
    logic [3:0]    alu_funct;
    logic [31:0]   alu_in1;
    logic [31:0]   alu_in2;
    logic [31:0]   alu_out;

    assign resp_valid = (count != '0);
    assign pop        = resp_valid && resp_ready;
    // a pop in the same cycle frees the slot the new push will use
    assign can_accept = (count < FULL) || ((count == FULL) && pop);

    always_comb begin
        gnt = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt = prio;
        end else if (req1_valid) begin
            gnt = 1'b1;
        end
    end

    assign req0_ready = can_accept && req0_valid && !gnt;
    assign req1_ready = can_accept && req1_valid && gnt;
    assign push       = req0_ready || req1_ready;

    assign alu_funct = gnt ? req1_funct : req0_funct;
    assign alu_in1   = gnt ? req1_in1   : req0_in1;
    assign alu_in2   = gnt ? req1_in2   : req0_in2;

    alu u_alu (
        .funct (alu_funct),
        .in1   (alu_in1),
        .in2   (alu_in2),
        .out   (alu_out)
    );

    // head drives the outputs while non-empty; otherwise the last popped entry is held
    assign resp_out = resp_valid ? mem[rptr]     : last_out;
    assign resp_src = resp_valid ? src_mem[rptr] : last_src;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            prio     <= 1'b0;
            last_out <= '0;
            last_src <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i]     <= '0;
                src_mem[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                mem[wptr]     <= alu_out;
                src_mem[wptr] <= gnt;
                wptr          <= wptr + PW'(1);
                prio          <= ~gnt;
            end
            if (pop) begin
                rptr     <= rptr + PW'(1);
                last_out <= mem[rptr];
                last_src <= src_mem[rptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: ALU vector table through req0, then
// hand-written sequences for round-robin, backpressure, fairness and async reset.

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [3:0]  req0_funct;
    logic [31:0] req0_in1, req0_in2;
    logic        req1_valid, req1_ready;
    logic [3:0]  req1_funct;
    logic [31:0] req1_in1, req1_in2;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_out;
    logic        resp_src;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_funct (req0_funct),
        .req0_in1   (req0_in1),
        .req0_in2   (req0_in2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_funct (req1_funct),
        .req1_in1   (req1_in1),
        .req1_in2   (req1_in2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_out   (resp_out),
        .resp_src   (resp_src)
    );

    typedef struct {
        logic [3:0]  funct;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 32'd5,        32'd7,        32'd12};
        vecs[1]  = '{4'b0001, 32'd10,       32'd3,        32'd7};
        vecs[2]  = '{4'b0001, 32'd3,        32'd10,       32'hFFFF_FFF9};
        vecs[3]  = '{4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
        vecs[4]  = '{4'b0011, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01};
        vecs[5]  = '{4'b0100, 32'hF000_0000, 32'h0000_000F, 32'h0FFF_FFF0};
        vecs[6]  = '{4'b0101, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F};
        vecs[7]  = '{4'b0110, 32'd4,        32'd1,        32'd16};
        vecs[8]  = '{4'b0111, 32'd4,        32'h8000_0000, 32'hF800_0000};
        vecs[9]  = '{4'b1000, 32'd4,        32'h8000_0000, 32'h0800_0000};
        vecs[10] = '{4'b1001, 32'hFFFF_FFFF, 32'd1,        32'd1};
        vecs[11] = '{4'b1001, 32'd1,        32'hFFFF_FFFF, 32'd0};
        vecs[12] = '{4'b1010, 32'hFFFF_FFFF, 32'd1,        32'd0};
        vecs[13] = '{4'b1111, 32'd99,       32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[14] = '{4'b1011, 32'd5,        32'd7,        32'd0};

        reset = 1'b1;
        req0_valid = 0; req0_funct = 0; req0_in1 = 0; req0_in2 = 0;
        req1_valid = 0; req1_funct = 0; req1_in1 = 0; req1_in2 = 0;
        resp_ready = 1'b1;
        #12;
        chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("reset_resp_out", resp_out, 32'd0);
        chk("reset_resp_src", {31'b0, resp_src}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ALU vector table through req0 alone, one result per two cycles
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            req0_valid = 1'b1;
            req0_funct = vecs[i].funct;
            req0_in1   = vecs[i].in1;
            req0_in2   = vecs[i].in2;
            #1;
            chk($sformatf("vec%0d_ready0", i), {31'b0, req0_ready}, 32'd1);
            @(negedge clk);
            req0_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d_resp_valid", i), {31'b0, resp_valid}, 32'd1);
            chk($sformatf("vec%0d_resp_out", i), resp_out, vecs[i].exp);
            chk($sformatf("vec%0d_resp_src", i), {31'b0, resp_src}, 32'd0);
        end

        // round-robin alternation with both requesters always valid
        do_reset();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_funct = 4'b0001; req0_in1 = 32'd10; req0_in2 = 32'd3;
        req1_valid = 1'b1; req1_funct = 4'b1010; req1_in1 = 32'd1;  req1_in2 = 32'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d_ready0", k), {31'b0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d_ready1", k), {31'b0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k > 0) begin
                chk($sformatf("rr%0d_resp_valid", k), {31'b0, resp_valid}, 32'd1);
                chk($sformatf("rr%0d_resp_out", k), resp_out, (k % 2 == 1) ? 32'd7 : 32'd1);
                chk($sformatf("rr%0d_resp_src", k), {31'b0, resp_src}, (k % 2 == 1) ? 32'd0 : 32'd1);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("rr_last_out", resp_out, 32'd1);
        chk("rr_last_src", {31'b0, resp_src}, 32'd1);

        // backpressure: third op blocked until the first pop
        do_reset();
        resp_ready = 1'b0;
        req1_valid = 1'b1; req1_funct = 4'b0000; req1_in2 = 32'd10;
        for (int j = 0; j < 2; j++) begin
            req1_in1 = 32'(j + 1);
            #1;
            chk($sformatf("bp_op%0d_ready1", j), {31'b0, req1_ready}, 32'd1);
            @(negedge clk);
        end
        req1_in1 = 32'd3;
        #1;
        chk("bp_full_ready1", {31'b0, req1_ready}, 32'd0);
        chk("bp_full_head", resp_out, 32'd11);
        @(negedge clk);
        #1;
        chk("bp_full_ready1_hold", {31'b0, req1_ready}, 32'd0);
        resp_ready = 1'b1;
        #1;
        chk("bp_pop_ready1", {31'b0, req1_ready}, 32'd1);
        chk("bp_pop_head_src", {31'b0, resp_src}, 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        chk("bp_second_out", resp_out, 32'd12);
        @(negedge clk);
        #1;
        chk("bp_third_valid", {31'b0, resp_valid}, 32'd1);
        chk("bp_third_out", resp_out, 32'd13);
        @(negedge clk);
        #1;
        chk("bp_empty_valid", {31'b0, resp_valid}, 32'd0);
        chk("bp_empty_hold", resp_out, 32'd13);

        // fairness: a lone req0 grant hands the next tie to req1
        do_reset();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_funct = 4'b0000; req0_in1 = 32'd5; req0_in2 = 32'd7;
        #1;
        chk("fair_lone_ready0", {31'b0, req0_ready}, 32'd1);
        @(negedge clk);
        req1_valid = 1'b1; req1_funct = 4'b1111; req1_in1 = 32'd0; req1_in2 = 32'd42;
        #1;
        chk("fair_tie_ready1", {31'b0, req1_ready}, 32'd1);
        chk("fair_tie_ready0", {31'b0, req0_ready}, 32'd0);
        chk("fair_resp_out", resp_out, 32'd12);
        @(negedge clk);
        #1;
        chk("fair_next_ready0", {31'b0, req0_ready}, 32'd1);
        chk("fair_resp_req1", resp_out, 32'd42);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // asynchronous reset with two entries queued
        do_reset();
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_funct = 4'b0000; req0_in1 = 32'd1; req0_in2 = 32'd1;
        @(negedge clk);
        req0_in1 = 32'd2;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("ar_queued_valid", {31'b0, resp_valid}, 32'd1);
        chk("ar_queued_out", resp_out, 32'd2);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_mid_valid", {31'b0, resp_valid}, 32'd0);
        chk("ar_mid_out", resp_out, 32'd0);
        chk("ar_mid_src", {31'b0, resp_src}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_funct = 4'b0000; req0_in1 = 32'd20; req0_in2 = 32'd22;
        req1_valid = 1'b1; req1_funct = 4'b0000; req1_in1 = 32'd1;  req1_in2 = 32'd1;
        #1;
        chk("ar_after_valid", {31'b0, resp_valid}, 32'd0);
        chk("ar_after_ready0", {31'b0, req0_ready}, 32'd1);
        chk("ar_after_ready1", {31'b0, req1_ready}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("ar_after_resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("ar_after_resp_out", resp_out, 32'd42);
        chk("ar_after_resp_src", {31'b0, resp_src}, 32'd0);
        @(negedge clk);
        #1;
        chk("ar_after_drained", {31'b0, resp_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
